// File: rtl/nano_pkg.sv
// Shared definitions for the nano_rv32i memory arbiter.
//   arb_state_e   : arbiter FSM states (IDLE -> BUSY -> RESP -> IDLE)
//   gnt_e         : which core port owns the memory bus
//   TIMEOUT_RDATA : read data returned to the owner when the bus times out
package nano_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_e;

  localparam logic [31:0] TIMEOUT_RDATA = 32'h0000_0000;

endpackage

// File: rtl/mem_timeout_cnt.sv
// Bus-timeout counter for the memory arbiter.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   clr          : synchronous clear (takes priority over en)
//   en           : count one cycle
//   tc           : high while the count equals TIMEOUT_CYCLES-1
// With TIMEOUT_CYCLES == 0 the counter is removed and tc is tied low.
module mem_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  input  logic en,
  output logic tc
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_disabled
      assign tc = 1'b0;
    end else begin : g_enabled
      logic [CNT_W-1:0] count_reg;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          count_reg <= '0;
        end else if (clr) begin
          count_reg <= '0;
        end else if (en) begin
          count_reg <= count_reg + 1'b1;
        end
      end

      assign tc = (count_reg == CNT_W'(TIMEOUT_CYCLES - 1));
    end
  endgenerate

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-ported memory bus between the instruction-fetch
// port (i_*) and the load/store port (d_*) of the core. One transaction at a
// time, round-robin on ties, req/ack handshake on both sides, bus timeout.
// Ports:
//   clk_i, rst_i                 : clock, asynchronous active-high reset
//   i_req_i, i_addr_i            : fetch request (held until i_ack_o)
//   i_ack_o, i_rdata_o, i_err_o  : fetch completion pulse, data, timeout flag
//   d_req_i, d_we_i, d_addr_i,
//   d_wdata_i                    : load/store request (held until d_ack_o)
//   d_ack_o, d_rdata_o, d_err_o  : data completion pulse, load data, timeout flag
//   mem_req_o, mem_we_o,
//   mem_addr_o, mem_wdata_o      : memory request, held until ack or timeout
//   mem_ack_i, mem_rdata_i       : memory completion with read data
// All outputs come straight from registers.
module mem_arbiter
  import nano_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_req_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  output logic              i_ack_o,
  output logic [DATA_W-1:0] i_rdata_o,
  output logic              i_err_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_ack_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_err_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  arb_state_e state_reg, state_next;
  gnt_e       owner_reg, owner_next;
  gnt_e       last_grant_reg, last_grant_next;
  gnt_e       grant_owner;
  logic       grant_valid;
  logic       timeout_hit;

  logic              mem_req_reg, mem_req_next;
  logic              mem_we_reg, mem_we_next;
  logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
  logic [DATA_W-1:0] mem_wdata_reg, mem_wdata_next;
  logic              i_ack_reg, i_ack_next;
  logic              i_err_reg, i_err_next;
  logic [DATA_W-1:0] i_rdata_reg, i_rdata_next;
  logic              d_ack_reg, d_ack_next;
  logic              d_err_reg, d_err_next;
  logic [DATA_W-1:0] d_rdata_reg, d_rdata_next;

  // Counter is held clear while idle, so every transaction starts at zero.
  mem_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_timeout (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .clr  (state_reg == ST_IDLE),
    .en   (state_reg == ST_BUSY),
    .tc   (timeout_hit)
  );

  // Round-robin: on a tie the port that was not granted last wins.
  assign grant_valid = i_req_i | d_req_i;
  assign grant_owner = (d_req_i && (!i_req_i || last_grant_reg == GNT_I)) ? GNT_D : GNT_I;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = ST_IDLE;
    case (state_reg)
      ST_IDLE: state_next = grant_valid ? ST_BUSY : ST_IDLE;
      ST_BUSY: state_next = (mem_ack_i || timeout_hit) ? ST_RESP : ST_BUSY;
      default: state_next = ST_IDLE;
    endcase
  end

  // Output logic: next values of every registered output
  always_comb begin
    owner_next      = owner_reg;
    last_grant_next = last_grant_reg;
    mem_req_next    = mem_req_reg;
    mem_we_next     = mem_we_reg;
    mem_addr_next   = mem_addr_reg;
    mem_wdata_next  = mem_wdata_reg;
    i_ack_next      = 1'b0;
    i_err_next      = 1'b0;
    i_rdata_next    = i_rdata_reg;
    d_ack_next      = 1'b0;
    d_err_next      = 1'b0;
    d_rdata_next    = d_rdata_reg;

    case (state_reg)
      ST_IDLE: begin
        if (grant_valid) begin
          owner_next      = grant_owner;
          last_grant_next = grant_owner;
          mem_req_next    = 1'b1;
          if (grant_owner == GNT_D) begin
            mem_we_next    = d_we_i;
            mem_addr_next  = d_addr_i;
            mem_wdata_next = d_wdata_i;
          end else begin
            mem_we_next   = 1'b0;
            mem_addr_next = i_addr_i;
          end
        end
      end
      ST_BUSY: begin
        // An ack arriving on the threshold cycle wins over the timeout.
        if (mem_ack_i || timeout_hit) begin
          mem_req_next = 1'b0;
          if (owner_reg == GNT_D) begin
            d_ack_next = 1'b1;
            d_err_next = !mem_ack_i;
            if (!mem_ack_i) begin
              d_rdata_next = DATA_W'(TIMEOUT_RDATA);
            end else if (!mem_we_reg) begin
              d_rdata_next = mem_rdata_i;
            end
          end else begin
            i_ack_next   = 1'b1;
            i_err_next   = !mem_ack_i;
            i_rdata_next = mem_ack_i ? mem_rdata_i : DATA_W'(TIMEOUT_RDATA);
          end
        end
      end
      default: ;
    endcase
  end

  // Output / datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      owner_reg      <= GNT_I;
      last_grant_reg <= GNT_I;
      mem_req_reg    <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      i_ack_reg      <= 1'b0;
      i_err_reg      <= 1'b0;
      i_rdata_reg    <= '0;
      d_ack_reg      <= 1'b0;
      d_err_reg      <= 1'b0;
      d_rdata_reg    <= '0;
    end else begin
      owner_reg      <= owner_next;
      last_grant_reg <= last_grant_next;
      mem_req_reg    <= mem_req_next;
      mem_we_reg     <= mem_we_next;
      mem_addr_reg   <= mem_addr_next;
      mem_wdata_reg  <= mem_wdata_next;
      i_ack_reg      <= i_ack_next;
      i_err_reg      <= i_err_next;
      i_rdata_reg    <= i_rdata_next;
      d_ack_reg      <= d_ack_next;
      d_err_reg      <= d_err_next;
      d_rdata_reg    <= d_rdata_next;
    end
  end

  assign mem_req_o   = mem_req_reg;
  assign mem_we_o    = mem_we_reg;
  assign mem_addr_o  = mem_addr_reg;
  assign mem_wdata_o = mem_wdata_reg;
  assign i_ack_o     = i_ack_reg;
  assign i_err_o     = i_err_reg;
  assign i_rdata_o   = i_rdata_reg;
  assign d_ack_o     = d_ack_reg;
  assign d_err_o     = d_err_reg;
  assign d_rdata_o   = d_rdata_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. The bench plays both core ports and
// the memory; a transaction-level model predicts grants, completion timing,
// read data and error flags from the arbiter's rules.
module tb_mem_arbiter;

  localparam int ADDR_W         = 32;
  localparam int DATA_W         = 32;
  localparam int TIMEOUT_CYCLES = 16;
  localparam int CNT_W          = 5;
  localparam int NEVER          = 999;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic              i_req_i = 1'b0;
  logic [ADDR_W-1:0] i_addr_i = '0;
  logic              i_ack_o;
  logic [DATA_W-1:0] i_rdata_o;
  logic              i_err_o;
  logic              d_req_i = 1'b0;
  logic              d_we_i = 1'b0;
  logic [ADDR_W-1:0] d_addr_i = '0;
  logic [DATA_W-1:0] d_wdata_i = '0;
  logic              d_ack_o;
  logic [DATA_W-1:0] d_rdata_o;
  logic              d_err_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_ack_i = 1'b0;
  logic [DATA_W-1:0] mem_rdata_i = '0;

  always #5 clk_i = ~clk_i;

  mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_ack_o(i_ack_o), .i_rdata_o(i_rdata_o), .i_err_o(i_err_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_ack_o(d_ack_o), .d_rdata_o(d_rdata_o), .d_err_o(d_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model state ----------------
  bit          i_pend, d_pend, d_we_q;
  logic [31:0] i_addr_q, d_addr_q, d_wdata_q;
  bit          m_busy, m_cool;
  bit          m_owner;          // 1 = data port, 0 = fetch port
  bit          m_last;           // port granted last, 0 (fetch) after reset
  int          busy_n, lat;
  int          forced_lat = -1;
  bit          ack_driven;
  logic [31:0] txn_rdata, exp_i_rdata, exp_d_rdata;
  logic [31:0] mem_model [logic [31:0]];
  int          req_pct = 0;
  bit          keep_both = 0;
  int          n_txn = 0;

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return {a[15:0], 16'hA5A5} ^ 32'h5A00_0000;
  endfunction

  task automatic drive_ports();
    i_req_i   = i_pend;
    i_addr_i  = i_addr_q;
    d_req_i   = d_pend;
    d_we_i    = d_we_q;
    d_addr_i  = d_addr_q;
    d_wdata_i = d_wdata_q;
  endtask

  task automatic issue_fetch(input logic [31:0] a);
    i_pend = 1; i_addr_q = a;
    drive_ports();
  endtask

  task automatic issue_data(input bit we, input logic [31:0] a, input logic [31:0] wd);
    d_pend = 1; d_we_q = we; d_addr_q = a; d_wdata_q = wd;
    drive_ports();
  endtask

  function automatic int pick_lat();
    int r;
    r = $urandom_range(0, 19);
    if (r < 14) return r % 4;
    if (r < 17) return TIMEOUT_CYCLES - 1;
    if (r < 19) return NEVER;
    return 7;
  endfunction

  task automatic complete(input bit err);
    logic [31:0] exp_rd;
    check("mem_req_drop", mem_req_o, 0);
    check("i_ack", i_ack_o, !m_owner);
    check("d_ack", d_ack_o, m_owner);
    if (m_owner) begin
      if (err) exp_d_rdata = 0;
      else if (!d_we_q) exp_d_rdata = txn_rdata;
      check("d_err", d_err_o, err);
      check("d_rdata", d_rdata_o, exp_d_rdata);
      exp_rd = exp_d_rdata;
      d_pend = 0;
    end else begin
      exp_i_rdata = err ? 32'h0 : txn_rdata;
      check("i_err", i_err_o, err);
      check("i_rdata", i_rdata_o, exp_i_rdata);
      exp_rd = exp_i_rdata;
      i_pend = 0;
    end
    n_txn++;
    $display("txn %0d port=%s we=%0d addr=0x%08h rdata=0x%08h err=%0d busy_cycles=%0d",
             n_txn, m_owner ? "D" : "I", m_owner && d_we_q, m_owner ? d_addr_q : i_addr_q,
             exp_rd, err, busy_n);
    m_busy = 0;
    m_cool = 1;
  endtask

  // One clock: observe outputs at the falling edge, then drive new inputs.
  task automatic cycle();
    logic [31:0] a;
    @(negedge clk_i);
    if (m_busy) begin
      if (ack_driven) begin
        complete(0);
      end else if (TIMEOUT_CYCLES != 0 && busy_n == TIMEOUT_CYCLES) begin
        complete(1);
      end else begin
        check("busy_mem_req", mem_req_o, 1);
        check("busy_acks", {30'd0, i_ack_o, d_ack_o}, 0);
        check("busy_addr", mem_addr_o, m_owner ? d_addr_q : i_addr_q);
        check("busy_we", mem_we_o, m_owner && d_we_q);
        if (m_owner && d_we_q) check("busy_wdata", mem_wdata_o, d_wdata_q);
        busy_n++;
      end
    end else if (m_cool) begin
      check("resp_mem_req", mem_req_o, 0);
      check("resp_acks", {30'd0, i_ack_o, d_ack_o}, 0);
      m_cool = 0;
    end else if (i_pend || d_pend) begin
      m_owner = (i_pend && d_pend) ? !m_last : d_pend;
      m_last  = m_owner;
      check("grant_mem_req", mem_req_o, 1);
      check("grant_addr", mem_addr_o, m_owner ? d_addr_q : i_addr_q);
      check("grant_we", mem_we_o, m_owner && d_we_q);
      if (m_owner && d_we_q) check("grant_wdata", mem_wdata_o, d_wdata_q);
      check("grant_acks", {30'd0, i_ack_o, d_ack_o}, 0);
      m_busy = 1;
      busy_n = 1;
      if (forced_lat >= 0) begin lat = forced_lat; forced_lat = -1; end
      else lat = pick_lat();
    end else begin
      check("idle_mem_req", mem_req_o, 0);
      check("idle_acks", {30'd0, i_ack_o, d_ack_o}, 0);
    end

    // memory side
    ack_driven = m_busy && (busy_n - 1 == lat);
    if (ack_driven) begin
      mem_ack_i = 1;
      a = m_owner ? d_addr_q : i_addr_q;
      if (m_owner && d_we_q) begin
        mem_model[a] = d_wdata_q;
        mem_rdata_i  = $urandom;
      end else begin
        txn_rdata   = mem_read(a);
        mem_rdata_i = txn_rdata;
      end
    end else begin
      mem_ack_i   = !m_busy && ($urandom_range(0, 3) == 0);
      mem_rdata_i = $urandom;
    end

    // requester side
    if (!i_pend && (keep_both || $urandom_range(0, 99) < req_pct))
      issue_fetch({16'h0, 4'h1, 8'($urandom_range(0, 255)), 2'b00, 2'b00});
    if (!d_pend && (keep_both || $urandom_range(0, 99) < req_pct))
      issue_data(1'($urandom_range(0, 1)), {16'h0, 4'h2, 8'($urandom_range(0, 31)), 4'h0}, $urandom);
    drive_ports();
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((m_busy || m_cool || i_pend || d_pend) && k < 300) begin
      cycle();
      k++;
    end
    check("drain_bound", k < 300, 1);
  endtask

  initial begin
    int k;
    int d_grants;
    // asynchronous reset, checked before any clock edge
    #1 rst_i = 1;
    #1;
    check("rst_mem_req", mem_req_o, 0);
    check("rst_mem_we", mem_we_o, 0);
    check("rst_mem_addr", mem_addr_o, 0);
    check("rst_mem_wdata", mem_wdata_o, 0);
    check("rst_acks_errs", {28'd0, i_ack_o, i_err_o, d_ack_o, d_err_o}, 0);
    check("rst_i_rdata", i_rdata_o, 0);
    check("rst_d_rdata", d_rdata_o, 0);
    repeat (2) @(negedge clk_i);
    rst_i = 0;
    exp_i_rdata = 0; exp_d_rdata = 0;
    m_last = 0;

    // single fetch, memory acks in first BUSY cycle
    mem_model[32'h100] = 32'h0050_0093;
    forced_lat = 0;
    issue_fetch(32'h100);
    drain();

    // store with three wait cycles; d_rdata must stay unchanged
    forced_lat = 3;
    issue_data(1, 32'h2000, 32'hCAFE_F00D);
    drain();
    check("store_mem_model", mem_read(32'h2000), 32'hCAFE_F00D);

    // load that times out
    forced_lat = NEVER;
    issue_data(0, 32'h3000, 32'h0);
    drain();

    // ack on the threshold cycle: normal completion
    mem_model[32'h3004] = 32'h1234_5678;
    forced_lat = TIMEOUT_CYCLES - 1;
    issue_data(0, 32'h3004, 32'h0);
    drain();

    // contention: both ports requesting continuously
    keep_both = 1;
    d_grants = 0;
    k = 0;
    while (n_txn < 12 && k < 500) begin cycle(); k++; end
    keep_both = 0;
    drain();

    // randomized traffic
    req_pct = 35;
    repeat (1500) cycle();
    req_pct = 0;
    drain();

    // reset in the middle of a fetch
    forced_lat = NEVER;
    issue_fetch(32'h400);
    k = 0;
    while (!(m_busy && busy_n == 2) && k < 20) begin cycle(); k++; end
    check("rst_mid_reach_busy", m_busy && busy_n == 2, 1);
    #2 rst_i = 1;
    #1 check("rst_mid_mem_req_async", mem_req_o, 0);
    @(negedge clk_i);
    check("rst_mid_acks", {30'd0, i_ack_o, d_ack_o}, 0);
    rst_i = 0;
    m_busy = 0; m_cool = 0; m_last = 0; ack_driven = 0;
    i_pend = 0; d_pend = 0;
    mem_ack_i = 0;
    exp_i_rdata = 0; exp_d_rdata = 0;
    mem_model[32'h500] = 32'h0000_0513;
    mem_model[32'h600] = 32'h0BAD_CAFE;
    forced_lat = 1;
    issue_fetch(32'h500);
    issue_data(0, 32'h600, 32'h0);
    cycle();
    check("rst_tie_goes_to_d", m_busy && m_owner, 1);
    drain();

    repeat (3) cycle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported memory bus between the core's instruction-fetch port and its load/store port.
- The core gains a separate-Harvard-style interface on a unified memory.
- Sits between the nano_rv32i core ports and the system memory/bus.
- Sequences one transaction at a time, with round-robin fairness, a req/ack handshake on both sides and a bus-timeout guard.

Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width of all ports
- TIMEOUT_CYCLES, 16, max cycles in BUSY waiting for mem_ack_i before an error response; 0 disables the timeout
- CNT_W, 5, timeout counter width; must hold TIMEOUT_CYCLES

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous, active-high reset
- i_req_i  in  1  fetch request, held until i_ack_o
- i_addr_i  in  ADDR_W  fetch address, stable while i_req_i high
- i_ack_o  out  1  one-cycle fetch completion pulse
- i_rdata_o  out  DATA_W  fetched word, valid when i_ack_o high
- i_err_o  out  1  fetch timed out, valid with i_ack_o
- d_req_i  in  1  data request, held until d_ack_o
- d_we_i  in  1  1 = store, 0 = load
- d_addr_i  in  ADDR_W  data address
- d_wdata_i  in  DATA_W  store data
- d_ack_o  out  1  one-cycle data completion pulse
- d_rdata_o  out  DATA_W  load data, valid with d_ack_o
- d_err_o  out  1  data access timed out, valid with d_ack_o
- mem_req_o  out  1  memory request, held until mem_ack_i or timeout
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_ack_i  in  1  memory completion, same cycle as mem_rdata_i
- mem_rdata_i  in  DATA_W  memory read data

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE, last_grant=I, counter=0.
  - All outputs 0: mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, all acks, errs and rdata.
  - Reset mid-transaction drops mem_req_o at once, no response is issued, and the requester must re-request.
- FSM IDLE -> BUSY -> RESP -> IDLE. All outputs are registered.
- IDLE:
  - Samples i_req_i and d_req_i.
  - Only one requesting: grant it.
  - Both requesting: grant the port that is not last_grant. Reset value last_grant=I, so D wins the first tie.
  - On grant, at the clock edge:
    - latch the address, plus we and wdata (data port) into the mem_* registers;
    - set mem_req_o=1, record the grant owner, update last_grant, clear the counter, go to BUSY.
  - mem_req_o is therefore first high 1 cycle after the request is sampled.
- BUSY:
  - mem_req_o and mem_* held stable; the counter increments every cycle.
  - On mem_ack_i:
    - mem_req_o := 0;
    - for the owner: capture mem_rdata_i into its rdata on reads only (a store leaves d_rdata_o unchanged); pulse its ack_o; err_o=0;
    - go to RESP.
  - On timeout, when TIMEOUT_CYCLES!=0 and the counter equals TIMEOUT_CYCLES-1 with no ack:
    - mem_req_o := 0;
    - owner rdata := 0, owner ack_o=1, err_o=1;
    - go to RESP.
  - mem_ack_i in the same cycle as the timeout threshold takes priority: normal completion.
- RESP:
  - ack_o/err_o high for exactly this one cycle, then cleared.
  - Request inputs are ignored; the requester must drop req or present a new request by the following cycle.
  - Next state is always IDLE.
- Latency:
  - With memory acking in its first BUSY cycle: request sampled at cycle 0, mem_req_o high at cycle 1, ack_o at cycle 2. Total 2 cycles; 3 cycles per back-to-back transaction.
- mem_ack_i in IDLE or RESP is spurious and ignored.
- Non-owner requests stay pending and are never dropped.
- Both ports continuously requesting strictly alternate D, I, D, I, ...

Decomposition:
- Shared package nano_pkg:
  - FSM state encoding (IDLE, BUSY, RESP).
  - Grant-owner encoding (GNT_I=0, GNT_D=1).
  - Timeout error read value (0).
- One natural sub-module, mem_timeout_cnt:
  - clear/enable counter with a terminal-count flag, parameterised by TIMEOUT_CYCLES and CNT_W.
  - Outputs constant 0 when disabled.

Test Plan:
- Single fetch: i_req_i=1, i_addr_i=0x100, mem acks 1 cycle after mem_req_o with 0x00500093 -> mem_addr_o=0x100, mem_we_o=0, i_ack_o pulses 1 cycle with i_rdata_o=0x00500093, i_err_o=0.
- Store: d_req_i=1, d_we_i=1, d_addr_i=0x2000, d_wdata_i=0xCAFEF00D, ack after 3 wait cycles -> mem_we_o=1, mem_wdata_o=0xCAFEF00D held 4 cycles, d_ack_o pulse, d_rdata_o unchanged.
- Contention: both requesting from reset, 4 transactions each -> grant order D, I, D, I, ...; no request lost; each ack pulse exactly 1 cycle.
- Timeout: TIMEOUT_CYCLES=16, d load to 0x3000, memory never acks -> mem_req_o high exactly 16 cycles, then d_ack_o=1, d_err_o=1, d_rdata_o=0.
- Ack at threshold: mem_ack_i on the 16th BUSY cycle with 0x12345678 -> normal completion, err_o=0, rdata=0x12345678.
- Reset mid-BUSY: assert rst_i 2 cycles into a fetch -> mem_req_o falls without a clock edge, no ack issued, next tie goes to D.
